// File: rtl/tw_slave_if.sv
// rtl/tw_slave_if.sv - 3-wire slave bus bundle: serial clock/CS, register bus, status
interface tw_slave_if #(
   parameter int TW_ADDRESS_BITS = 7,
   parameter int TW_DATA_BITS    = 8
);
   logic                       in_tw_clock;
   logic                       in_tw_cs;
   logic                       out_tw_dir;
   logic [TW_ADDRESS_BITS-1:0] out_reg_addr;
   logic [TW_DATA_BITS-1:0]    out_reg_wdata;
   logic                       out_reg_we;
   logic                       out_reg_re;
   logic [TW_DATA_BITS-1:0]    in_reg_rdata;
   logic                       out_busy;
   logic                       out_abort;

   modport slave (
      input  in_tw_clock, in_tw_cs, in_reg_rdata,
      output out_tw_dir, out_reg_addr, out_reg_wdata, out_reg_we, out_reg_re,
             out_busy, out_abort
   );

   modport master (
      output in_tw_clock, in_tw_cs, in_reg_rdata,
      input  out_tw_dir, out_reg_addr, out_reg_wdata, out_reg_we, out_reg_re,
             out_busy, out_abort
   );
endinterface

// File: rtl/tw_slave.sv
// rtl/tw_slave.sv - 3-wire serial responder decoding frames onto a parallel register bus
module tw_slave #(
   parameter int TW_ADDRESS_BITS = 7,
   parameter int TW_DATA_BITS    = 8
) (
   input  logic       in_clk,
   input  logic       in_reset_n,
   inout  wire        io_tw_data,
   tw_slave_if.slave  bus
);
   localparam int A  = TW_ADDRESS_BITS;
   localparam int D  = TW_DATA_BITS;
   localparam int CW = $clog2(((A > D) ? A : D) + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_CMD   = 3'd1;
   localparam logic [2:0] ST_ADDR  = 3'd2;
   localparam logic [2:0] ST_WDATA = 3'd3;
   localparam logic [2:0] ST_RDATA = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   logic [1:0]    clk_sync, cs_sync, dat_sync;
   logic          clk_d, cs_d;
   logic          clk_s, cs_s, dat_s;
   logic          clk_rise, clk_fall, cs_rise;

   logic [2:0]    state;
   logic [CW-1:0] cnt;
   logic          rw;
   logic [A-2:0]  addr_sh;
   logic [D-2:0]  wd_sh;
   logic [D-1:0]  tx_sh;
   logic          tx_bit;
   logic          dir;
   logic          re_d;
   logic [A-1:0]  reg_addr;
   logic [D-1:0]  reg_wdata;
   logic          we, re, abort;

   assign clk_s    = clk_sync[1];
   assign cs_s     = cs_sync[1];
   assign dat_s    = dat_sync[1];
   assign clk_rise = clk_s & ~clk_d;
   assign clk_fall = ~clk_s & clk_d;
   assign cs_rise  = cs_s & ~cs_d;

   assign io_tw_data        = dir ? tx_bit : 1'bz;
   assign bus.out_tw_dir    = dir;
   assign bus.out_reg_addr  = reg_addr;
   assign bus.out_reg_wdata = reg_wdata;
   assign bus.out_reg_we    = we;
   assign bus.out_reg_re    = re;
   assign bus.out_abort     = abort;
   assign bus.out_busy      = (state != ST_IDLE);

   // Two-stage synchronizers plus one delayed copy for edge detection
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         clk_sync <= '0;
         cs_sync  <= '0;
         dat_sync <= '0;
         clk_d    <= 1'b0;
         cs_d     <= 1'b0;
      end else begin
         clk_sync <= {clk_sync[0], bus.in_tw_clock};
         cs_sync  <= {cs_sync[0], bus.in_tw_cs};
         dat_sync <= {dat_sync[0], io_tw_data};
         clk_d    <= clk_s;
         cs_d     <= cs_s;
      end
   end

   // Frame decoder: CS loss has priority over any clock edge seen in the same cycle
   always_ff @(posedge in_clk or negedge in_reset_n) begin
      if (!in_reset_n) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         rw        <= 1'b0;
         addr_sh   <= '0;
         wd_sh     <= '0;
         tx_sh     <= '0;
         tx_bit    <= 1'b0;
         dir       <= 1'b0;
         re_d      <= 1'b0;
         reg_addr  <= '0;
         reg_wdata <= '0;
         we        <= 1'b0;
         re        <= 1'b0;
         abort     <= 1'b0;
      end else begin
         we    <= 1'b0;
         re    <= 1'b0;
         abort <= 1'b0;
         re_d  <= re;
         // Read data arrives one cycle after the read strobe
         if (re_d) tx_sh <= bus.in_reg_rdata;
         if (state != ST_IDLE && !cs_s) begin
            if (state != ST_DONE) abort <= 1'b1;
            dir   <= 1'b0;
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: if (cs_rise) begin
                  cnt   <= '0;
                  state <= ST_CMD;
               end
               ST_CMD: if (clk_rise) begin
                  rw    <= dat_s;
                  cnt   <= '0;
                  state <= ST_ADDR;
               end
               ST_ADDR: if (clk_rise) begin
                  addr_sh <= {addr_sh, dat_s};
                  cnt     <= cnt + CW'(1);
                  if (cnt == CW'(A - 1)) begin
                     reg_addr <= {addr_sh, dat_s};
                     cnt      <= '0;
                     if (rw) begin
                        re    <= 1'b1;
                        state <= ST_RDATA;
                     end else begin
                        state <= ST_WDATA;
                     end
                  end
               end
               ST_WDATA: if (clk_rise) begin
                  wd_sh <= {wd_sh, dat_s};
                  cnt   <= cnt + CW'(1);
                  if (cnt == CW'(D - 1)) begin
                     reg_wdata <= {wd_sh, dat_s};
                     we        <= 1'b1;
                     cnt       <= '0;
                     state     <= ST_DONE;
                  end
               end
               ST_RDATA: begin
                  if (clk_fall) begin
                     dir    <= 1'b1;
                     tx_bit <= tx_sh[D-1];
                     tx_sh  <= {tx_sh[D-2:0], 1'b0};
                  end else if (clk_rise) begin
                     cnt <= cnt + CW'(1);
                     if (cnt == CW'(D - 1)) begin
                        cnt   <= '0;
                        state <= ST_DONE;
                     end
                  end
               end
               ST_DONE: if (clk_fall) dir <= 1'b0;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end
endmodule
